// File: rtl/sram_1rw1r_wmask_if.sv
// ----------------------------------------------------------------------------
// sram_1rw1r_wmask_if
//
// Bus bundle for the two-port SRAM. Port 0 is read/write with a per-slice
// write mask. Port 1 is read-only.
//
// Handshake: there is no request/grant pair. An access is taken on a rising
// clock edge when ready=1 and that port's chip select (csb0/csb1) is low.
// Read data is not back-pressured. Each accepted read produces exactly one
// single-cycle valid strobe (valid0/valid1) READ_LATENCY cycles later. dout
// holds its last read value between strobes.
//
// Signals (master = requester, slave = memory):
//   csb0, web0, wmask0, addr0, din0 : port-0 select, write enable, mask,
//                                     address and write data (master -> slave)
//   csb1, addr1                     : port-1 select and address (master -> slave)
//   dout0, valid0, dout1, valid1    : read data and strobes (slave -> master)
//   ready                           : accesses accepted (slave -> master)
//   collision                       : same-address write/read flag (slave -> master)
// ----------------------------------------------------------------------------
interface sram_1rw1r_wmask_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_WMASKS = 4
);
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  valid0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  valid1;
    logic                  ready;
    logic                  collision;

    modport master (
        output csb0, web0, wmask0, addr0, din0, csb1, addr1,
        input  dout0, valid0, dout1, valid1, ready, collision
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output dout0, valid0, dout1, valid1, ready, collision
    );
endinterface

// File: rtl/sram_1rw1r_wmask.sv
// ----------------------------------------------------------------------------
// sram_1rw1r_wmask
//
// Single-clock SRAM with one read/write port (port 0, byte-slice write mask)
// and one read-only port (port 1). After reset an init FSM optionally
// zero-fills the array one word per clock. Accesses are accepted only once
// the FSM reaches RUN.
//
// Ports:
//   clk         : single clock; all state changes on its rising edge
//   rstb        : asynchronous active-low reset (memory contents untouched)
//   bus         : sram_1rw1r_wmask_if.slave (see interface header)
//   dbg_state_o : init FSM state (0 = INIT, 1 = RUN)
// ----------------------------------------------------------------------------
module sram_1rw1r_wmask #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int NUM_WMASKS   = 4,
    parameter int READ_LATENCY = 1,
    parameter int INIT_ZERO    = 1
) (
    input  logic              clk,
    input  logic              rstb,
    sram_1rw1r_wmask_if.slave bus,
    output logic [0:0]        dbg_state_o
);

    // Elaboration-time parameter checks
    if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_mask
        $error("sram_1rw1r_wmask: DATA_WIDTH must be a multiple of NUM_WMASKS");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("sram_1rw1r_wmask: READ_LATENCY must be 1 or 2");
    end
    if (RAM_DEPTH < 1 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("sram_1rw1r_wmask: RAM_DEPTH must be in 1..2**ADDR_WIDTH");
    end

    localparam int SLICE_W = DATA_WIDTH / NUM_WMASKS;
    // One extra bit so that RAM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

    logic                  run;
    logic                  wr_acc, rd0_acc, rd1_acc;
    logic                  addr0_ok, addr1_ok;
    logic [DATA_WIDTH-1:0] rd0_word, rd1_word;

    logic                  fin0_vld, fin1_vld;
    logic [DATA_WIDTH-1:0] fin0_dat, fin1_dat;

    logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
    logic                  valid0_q, valid1_q;
    logic                  collision_q;

    // ------------------------------------------------------------------
    // Init FSM: INIT walks the counter over every word, then RUN forever.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (INIT_ZERO == 0 || init_cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign run      = (state_q == ST_RUN);
    assign wr_acc   = run && !bus.csb0 && !bus.web0;
    assign rd0_acc  = run && !bus.csb0 &&  bus.web0;
    assign rd1_acc  = run && !bus.csb1;
    assign addr0_ok = {1'b0, bus.addr0} < DEPTH_W;
    assign addr1_ok = {1'b0, bus.addr1} < DEPTH_W;

    // Reads see the array contents before this edge's write, which is what
    // gives port 1 the pre-write data on a same-address collision.
    assign rd0_word = addr0_ok ? mem[bus.addr0] : '0;
    assign rd1_word = addr1_ok ? mem[bus.addr1] : '0;

    // ------------------------------------------------------------------
    // Memory array. No reset: only INIT zero-fill and accepted writes change
    // it. The rstb gate keeps the held-in-INIT FSM from writing word 0 while
    // reset is still asserted.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstb) begin
            if (state_q == ST_INIT) begin
                if (INIT_ZERO != 0) begin
                    mem[init_cnt_q] <= '0;
                end
            end else if (wr_acc && addr0_ok) begin
                for (int i = 0; i < NUM_WMASKS; i++) begin
                    if (bus.wmask0[i]) begin
                        mem[bus.addr0][i*SLICE_W +: SLICE_W] <= bus.din0[i*SLICE_W +: SLICE_W];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: an optional middle stage for READ_LATENCY = 2.
    // ------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_vld0_q, s1_vld1_q;
        logic [DATA_WIDTH-1:0] s1_dat0_q, s1_dat1_q;

        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                s1_vld0_q <= 1'b0;
                s1_vld1_q <= 1'b0;
                s1_dat0_q <= '0;
                s1_dat1_q <= '0;
            end else begin
                s1_vld0_q <= rd0_acc;
                s1_vld1_q <= rd1_acc;
                if (rd0_acc) s1_dat0_q <= rd0_word;
                if (rd1_acc) s1_dat1_q <= rd1_word;
            end
        end

        assign fin0_vld = s1_vld0_q;
        assign fin0_dat = s1_dat0_q;
        assign fin1_vld = s1_vld1_q;
        assign fin1_dat = s1_dat1_q;
    end else begin : g_lat1
        assign fin0_vld = rd0_acc;
        assign fin0_dat = rd0_word;
        assign fin1_vld = rd1_acc;
        assign fin1_dat = rd1_word;
    end

    // Output stage: dout only moves when a read completes, so it holds the
    // last read value across idle cycles and writes.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            dout0_q     <= '0;
            dout1_q     <= '0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            valid0_q    <= fin0_vld;
            valid1_q    <= fin1_vld;
            if (fin0_vld) dout0_q <= fin0_dat;
            if (fin1_vld) dout1_q <= fin1_dat;
            collision_q <= wr_acc && rd1_acc && (bus.addr0 == bus.addr1);
        end
    end

    assign bus.dout0     = dout0_q;
    assign bus.dout1     = dout1_q;
    assign bus.valid0    = valid0_q;
    assign bus.valid1    = valid1_q;
    assign bus.ready     = run;
    assign bus.collision = collision_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// ----------------------------------------------------------------------------
// tb_sram_1rw1r_wmask
//
// Two instances share one stimulus stream:
//   dut_a : ADDR_WIDTH=4, RAM_DEPTH=16, READ_LATENCY=1
//   dut_b : ADDR_WIDTH=4, RAM_DEPTH=12, READ_LATENCY=2
// A behavioural model (word arrays plus a per-port history ring indexed by
// edge count) predicts every output. A negedge process compares it against
// both instances each cycle. Directed sections add literal expectations.
// ----------------------------------------------------------------------------
module tb_sram_1rw1r_wmask;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NM = 4;
    localparam int SW = DW / NM;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic          csb0, web0, csb1;
    logic [NM-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0;

    sram_1rw1r_wmask_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) if_a ();
    sram_1rw1r_wmask_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) if_b ();

    assign if_a.csb0 = csb0;  assign if_b.csb0 = csb0;
    assign if_a.web0 = web0;  assign if_b.web0 = web0;
    assign if_a.wmask0 = wmask0;  assign if_b.wmask0 = wmask0;
    assign if_a.addr0 = addr0;  assign if_b.addr0 = addr0;
    assign if_a.din0 = din0;  assign if_b.din0 = din0;
    assign if_a.csb1 = csb1;  assign if_b.csb1 = csb1;
    assign if_a.addr1 = addr1;  assign if_b.addr1 = addr1;

    logic [0:0] dbg_a, dbg_b;

    sram_1rw1r_wmask #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(16), .NUM_WMASKS(NM),
        .READ_LATENCY(1), .INIT_ZERO(1)
    ) dut_a (
        .clk(clk), .rstb(rstb), .bus(if_a), .dbg_state_o(dbg_a)
    );

    sram_1rw1r_wmask #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(12), .NUM_WMASKS(NM),
        .READ_LATENCY(2), .INIT_ZERO(1)
    ) dut_b (
        .clk(clk), .rstb(rstb), .bus(if_b), .dbg_state_o(dbg_b)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } rd_t;

    int            depth_m [2] = '{16, 12};
    int            lat_m   [2] = '{1, 2};
    logic [DW-1:0] mm      [2][16];
    bit            rdy_m   [2];
    int            iptr_m  [2];
    int            ec_m    [2];
    rd_t           ring0   [2][4];
    rd_t           ring1   [2][4];
    logic          exp_rdy [2];
    logic          exp_v0  [2];
    logic          exp_v1  [2];
    logic          exp_col [2];
    logic [DW-1:0] exp_d0  [2];
    logic [DW-1:0] exp_d1  [2];

    task automatic model_reset(input int k);
        rdy_m[k]  = 1'b0;
        iptr_m[k] = 0;
        ec_m[k]   = 0;
        for (int j = 0; j < 4; j++) begin
            ring0[k][j] = '0;
            ring1[k][j] = '0;
        end
        exp_rdy[k] = 1'b0;
        exp_v0[k]  = 1'b0;
        exp_v1[k]  = 1'b0;
        exp_col[k] = 1'b0;
        exp_d0[k]  = '0;
        exp_d1[k]  = '0;
    endtask

    // One rising edge: a read issued at edge e becomes visible after edge
    // e + latency - 1, so each port keeps a short history of per-edge results.
    task automatic model_step(input int k);
        rd_t  r0, r1;
        logic col, w;
        int   a0, a1;
        r0  = '0;
        r1  = '0;
        col = 1'b0;
        a0  = int'(addr0);
        a1  = int'(addr1);
        ec_m[k]++;
        if (!rdy_m[k]) begin
            mm[k][iptr_m[k]] = '0;
            iptr_m[k]++;
            if (iptr_m[k] == depth_m[k]) rdy_m[k] = 1'b1;
        end else begin
            if (!csb0 && web0) begin
                r0.v = 1'b1;
                r0.d = (a0 < depth_m[k]) ? mm[k][a0] : '0;
            end
            if (!csb1) begin
                r1.v = 1'b1;
                r1.d = (a1 < depth_m[k]) ? mm[k][a1] : '0;
            end
            w   = !csb0 && !web0;
            col = w && !csb1 && (a0 == a1);
            if (w && a0 < depth_m[k]) begin
                for (int i = 0; i < NM; i++) begin
                    if (wmask0[i]) mm[k][a0][SW*i +: SW] = din0[SW*i +: SW];
                end
            end
        end
        ring0[k][ec_m[k] % 4] = r0;
        ring1[k][ec_m[k] % 4] = r1;
        r0 = ring0[k][(ec_m[k] - lat_m[k] + 1) % 4];
        r1 = ring1[k][(ec_m[k] - lat_m[k] + 1) % 4];
        exp_v0[k] = r0.v;
        exp_v1[k] = r1.v;
        if (r0.v) exp_d0[k] = r0.d;
        if (r1.v) exp_d1[k] = r1.d;
        exp_col[k] = col;
        exp_rdy[k] = rdy_m[k];
    endtask

    always @(posedge clk) begin
        if (!rstb) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge rstb) begin
        model_reset(0);
        model_reset(1);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("a_ready",     if_a.ready,     exp_rdy[0]);
        chk("a_state",     dbg_a,          exp_rdy[0]);
        chk("a_valid0",    if_a.valid0,    exp_v0[0]);
        chk("a_valid1",    if_a.valid1,    exp_v1[0]);
        chk("a_dout0",     if_a.dout0,     exp_d0[0]);
        chk("a_dout1",     if_a.dout1,     exp_d1[0]);
        chk("a_collision", if_a.collision, exp_col[0]);
        chk("b_ready",     if_b.ready,     exp_rdy[1]);
        chk("b_state",     dbg_b,          exp_rdy[1]);
        chk("b_valid0",    if_b.valid0,    exp_v0[1]);
        chk("b_valid1",    if_b.valid1,    exp_v1[1]);
        chk("b_dout0",     if_b.dout0,     exp_d0[1]);
        chk("b_dout1",     if_b.dout1,     exp_d1[1]);
        chk("b_collision", if_b.collision, exp_col[1]);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        csb0   = 1'b1;
        web0   = 1'b1;
        csb1   = 1'b1;
        wmask0 = '0;
    endtask

    task automatic rand_inputs();
        csb0   = ($urandom_range(0, 3) == 0);
        web0   = 1'($urandom_range(0, 1));
        wmask0 = NM'($urandom_range(0, 15));
        addr0  = AW'($urandom_range(0, 15));
        din0   = $urandom;
        csb1   = ($urandom_range(0, 3) == 0);
        addr1  = ($urandom_range(0, 3) == 0) ? addr0 : AW'($urandom_range(0, 15));
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NM-1:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = AW'(a); din0 = d; wmask0 = m;
        tick();
        set_idle();
    endtask

    // Random accesses each cycle while waiting for ready; counts cycles from
    // release and any valid strobe seen before each instance reports ready.
    task automatic wait_ready(input int exp_a, input int exp_b, input string tag);
        int ra, rb, strobes;
        ra = -1;
        rb = -1;
        strobes = 0;
        for (int n = 1; n <= 40; n++) begin
            rand_inputs();
            @(posedge clk);
            @(negedge clk);
            if (ra < 0 && (if_a.valid0 || if_a.valid1)) strobes++;
            if (rb < 0 && (if_b.valid0 || if_b.valid1)) strobes++;
            if (ra < 0 && if_a.ready) ra = n;
            if (rb < 0 && if_b.ready) rb = n;
            if (ra >= 0 && rb >= 0) break;
        end
        set_idle();
        chk({tag, "_a_cycles"}, DW'(ra), DW'(exp_a));
        chk({tag, "_b_cycles"}, DW'(rb), DW'(exp_b));
        chk({tag, "_strobes"},  DW'(strobes), '0);
    endtask

    task automatic pipe_obs();
        logic [DW-1:0] e;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("pipe_b_v1", if_b.valid1, 1'b1);
        chk("pipe_b_d1", if_b.dout1, e);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        set_idle();
        addr0 = '0;
        addr1 = '0;
        din0  = '0;
        #1 rstb = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_a_ready",  if_a.ready,  1'b0);
        chk("rst_a_dout0",  if_a.dout0,  '0);
        chk("rst_b_valid1", if_b.valid1, 1'b0);
        tick();
        tick();
        rstb = 1'b1;

        // Zero-fill: 16 words on A, 12 on B
        wait_ready(16, 12, "init");
        tick();
        for (int i = 0; i < 16; i++) begin
            csb0 = 1'b0; web0 = 1'b1; addr0 = AW'(i);
            tick();
            set_idle();
            @(negedge clk);
            chk("init_a_zero", if_a.dout0, '0);
        end

        // Masked write
        do_write(3, 32'hAABBCCDD, 4'hF);
        do_write(3, 32'h11223344, 4'h5);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
        tick();
        set_idle();
        @(negedge clk);
        chk("mask_a_v0",       if_a.valid0, 1'b1);
        chk("mask_a_d0",       if_a.dout0,  32'hAA22CC44);
        chk("mask_b_v0_early", if_b.valid0, 1'b0);
        @(negedge clk);
        chk("mask_b_v0",       if_b.valid0, 1'b1);
        chk("mask_b_d0",       if_b.dout0,  32'hAA22CC44);
        chk("mask_a_v0_once",  if_a.valid0, 1'b0);

        // Zero-mask write leaves the word alone
        do_write(3, 32'hDEADBEEF, 4'h0);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd3;
        tick();
        set_idle();
        @(negedge clk);
        chk("mask0_a_d0", if_a.dout0, 32'hAA22CC44);

        // Collision: write 2 to addr 5 while port 1 reads addr 5
        do_write(5, 32'h1, 4'hF);
        csb0 = 1'b0; web0 = 1'b0; addr0 = 4'd5; din0 = 32'h2; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 4'd5;
        tick();
        set_idle();
        @(negedge clk);
        chk("col_a_d1",   if_a.dout1,     32'h1);
        chk("col_a_v1",   if_a.valid1,    1'b1);
        chk("col_a_flag", if_a.collision, 1'b1);
        chk("col_b_flag", if_b.collision, 1'b1);
        @(negedge clk);
        chk("col_a_flag_drop", if_a.collision, 1'b0);
        chk("col_b_d1",        if_b.dout1,     32'h1);
        chk("col_b_flag_drop", if_b.collision, 1'b0);
        csb1 = 1'b0; addr1 = 4'd5;
        tick();
        set_idle();
        @(negedge clk);
        chk("col_a_after", if_a.dout1, 32'h2);
        chk("hold_a_d0",   if_a.dout0, 32'hAA22CC44);

        // Pipelined reads on port 1 (B has latency 2)
        tick();
        for (int i = 0; i < 8; i++) begin
            do_write(i, 32'h100 + i, 4'hF);
            exp_q.push_back(32'h100 + i);
        end
        for (int i = 0; i < 8; i++) begin
            csb1 = 1'b0; addr1 = AW'(i);
            @(posedge clk);
            @(negedge clk);
            if (i == 0) chk("pipe_b_v1_lead", if_b.valid1, 1'b0);
            else        pipe_obs();
        end
        set_idle();
        @(posedge clk);
        @(negedge clk);
        pipe_obs();
        @(posedge clk);
        @(negedge clk);
        chk("pipe_b_v1_tail", if_b.valid1, 1'b0);

        // Out-of-range on B (depth 12); addr 13 is in range on A
        tick();
        do_write(13, 32'hFF, 4'hF);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 4'd13;
        tick();
        set_idle();
        @(negedge clk);
        chk("oor_a_d0", if_a.dout0, 32'hFF);
        @(negedge clk);
        chk("oor_b_v0", if_b.valid0, 1'b1);
        chk("oor_b_d0", if_b.dout0,  '0);
        tick();
        for (int i = 0; i < 12; i++) begin
            csb1 = 1'b0; addr1 = AW'(i);
            tick();
        end
        set_idle();
        tick();
        tick();

        // Reset in the middle of INIT (counter at 9)
        rstb = 1'b0;
        tick();
        tick();
        rstb = 1'b1;
        repeat (9) tick();
        chk("midinit_a_ready", if_a.ready, 1'b0);
        rstb = 1'b0;
        rand_inputs();
        tick();
        tick();
        rstb = 1'b1;
        wait_ready(16, 12, "reinit");
        tick();

        // Random traffic, with one reset while reads are in flight
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                csb0 = 1'b0; web0 = 1'b1; csb1 = 1'b0;
                tick();
                rstb = 1'b0;
                set_idle();
                @(negedge clk);
                chk("flush_b_v0", if_b.valid0, 1'b0);
                chk("flush_b_v1", if_b.valid1, 1'b0);
                @(posedge clk);
                @(negedge clk);
                chk("flush_b_v0_late", if_b.valid0, 1'b0);
                tick();
                rstb = 1'b1;
            end
            rand_inputs();
            tick();
        end
        set_idle();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
